mult_sequencer: RTL and testbench

MULT_SEQUENCER -- requirements
Module: mult_sequencer

---
 rtl/mult_pkg.sv | 12 +
 rtl/mult_sequencer_if.sv | 26 ++
 rtl/mult_sequencer.sv | 96 +++++++++
 tb/tb_mult_sequencer.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared operand width and state encoding for the add-shift multiplier.
package mult_pkg;
    localparam int WIDTH = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        ADD,
        SHIFT,
        DONE
    } state_t;
endpackage

// File: rtl/mult_sequencer_if.sv
// rtl/mult_sequencer_if.sv - operand, control and external adder signals of the multiplier.
interface mult_sequencer_if;
    import mult_pkg::*;

    logic             Run;
    logic             ClearA_LoadB;
    logic [WIDTH-1:0] Din;
    logic [WIDTH:0]   Add_S;
    logic [WIDTH-1:0] Add_A;
    logic [WIDTH-1:0] Add_B;
    logic             Fn;
    logic [WIDTH-1:0] Aval;
    logic [WIDTH-1:0] Bval;
    logic             Xval;
    logic             Busy;

    modport master (
        output Run, ClearA_LoadB, Din, Add_S,
        input  Add_A, Add_B, Fn, Aval, Bval, Xval, Busy
    );

    modport slave (
        input  Run, ClearA_LoadB, Din, Add_S,
        output Add_A, Add_B, Fn, Aval, Bval, Xval, Busy
    );
endinterface

// File: rtl/mult_sequencer.sv
// rtl/mult_sequencer.sv - signed 8x8 add-shift multiplier sequencer driving an external 9-bit add/sub.
module mult_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic            Clk,
    input  logic            Reset_n,
    mult_sequencer_if.slave bus
);
    import mult_pkg::*;

    localparam logic [3:0] LAST_BIT = 4'(WIDTH - 1);

    state_t           state, state_n;
    logic [3:0]       cnt, cnt_n;
    logic             x, x_n;
    logic [WIDTH-1:0] a, a_n;
    logic [WIDTH-1:0] b, b_n;
    logic [WIDTH-1:0] s, s_n;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= IDLE;
            cnt   <= '0;
            x     <= 1'b0;
            a     <= '0;
            b     <= '0;
            s     <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            x     <= x_n;
            a     <= a_n;
            b     <= b_n;
            s     <= s_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        x_n     = x;
        a_n     = a;
        b_n     = b;
        s_n     = s;
        case (state)
            IDLE: begin
                // Loading the multiplier wins over a start request in the same cycle.
                if (bus.ClearA_LoadB) begin
                    x_n = 1'b0;
                    a_n = '0;
                    b_n = bus.Din;
                end else if (bus.Run) begin
                    s_n     = bus.Din;
                    state_n = START;
                end
            end
            START: begin
                x_n     = 1'b0;
                a_n     = '0;
                cnt_n   = '0;
                state_n = ADD;
            end
            ADD: begin
                if (b[0]) begin
                    {x_n, a_n} = bus.Add_S;
                end
                state_n = SHIFT;
            end
            SHIFT: begin
                {x_n, a_n, b_n} = {x, x, a, b[WIDTH-1:1]};
                cnt_n           = cnt + 4'd1;
                state_n         = (cnt == LAST_BIT) ? DONE : ADD;
            end
            DONE: begin
                // Run must drop before another product can start.
                if (bus.ClearA_LoadB) begin
                    x_n = 1'b0;
                    a_n = '0;
                    b_n = bus.Din;
                end else if (!bus.Run) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // The sign-bit partial product carries negative weight, so the last step subtracts.
    assign bus.Fn    = (state == ADD) && (cnt == LAST_BIT);
    assign bus.Busy  = (state == START) || (state == ADD) || (state == SHIFT);
    assign bus.Add_A = a;
    assign bus.Add_B = s;
    assign bus.Aval  = a;
    assign bus.Bval  = b;
    assign bus.Xval  = x;
endmodule

// File: tb/tb_mult_sequencer.sv
// tb/tb_mult_sequencer.sv - randomized self-checking bench for mult_sequencer against a signed product model.
module tb_mult_sequencer;
    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    int   n_checks = 0;
    int   n_errors = 0;
    logic [7:0] model_b = 8'h00;

    mult_sequencer_if bus();

    mult_sequencer #(.WIDTH(8)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .bus     (bus)
    );

    always #5 Clk = ~Clk;

    // External 9-bit add/sub stage on sign-extended operands
    assign bus.Add_S = bus.Fn ? ({bus.Add_A[7], bus.Add_A} - {bus.Add_B[7], bus.Add_B})
                              : ({bus.Add_A[7], bus.Add_A} + {bus.Add_B[7], bus.Add_B});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_a"}, 32'(bus.Aval), 32'h0);
        check({tag, "_b"}, 32'(bus.Bval), 32'h0);
        check({tag, "_x"}, 32'(bus.Xval), 32'h0);
        check({tag, "_busy"}, 32'(bus.Busy), 32'h0);
        check({tag, "_fn"}, 32'(bus.Fn), 32'h0);
    endtask

    task automatic load(input logic [7:0] v);
        bus.ClearA_LoadB = 1'b1;
        bus.Din = v;
        tick();
        bus.ClearA_LoadB = 1'b0;
        model_b = v;
    endtask

    // Runs one product; leaves Run high and the design in DONE.
    task automatic do_run(input logic [7:0] mcand, input bit noise, input int hold);
        int p, ma, mb, cycles, fns;
        bit restarted;
        ma = $signed(mcand);
        mb = $signed(model_b);
        p = ma * mb;
        bus.Run = 1'b1;
        bus.ClearA_LoadB = 1'b0;
        bus.Din = mcand;
        tick();
        cycles = 0;
        fns = 0;
        while (bus.Busy && cycles < 100) begin
            if (bus.Fn) fns++;
            if (noise) begin
                bus.ClearA_LoadB = 1'($urandom);
                bus.Din = 8'($urandom);
                bus.Run = 1'($urandom);
            end
            tick();
            cycles++;
        end
        bus.ClearA_LoadB = 1'b0;
        bus.Run = 1'b1;
        check("latency", 32'(cycles), 32'd17);
        check("fn_pulses", 32'(fns), 32'd1);
        check("product", {16'h0, bus.Aval, bus.Bval}, 32'(p[15:0]));
        check("xval", 32'(bus.Xval), 32'(p[15]));
        if (hold > 0) begin
            restarted = 1'b0;
            for (int i = 0; i < hold; i++) begin
                tick();
                if (bus.Busy) restarted = 1'b1;
            end
            check("no_restart", 32'(restarted), 32'h0);
            check("held_product", {16'h0, bus.Aval, bus.Bval}, 32'(p[15:0]));
        end
        model_b = p[7:0];
    endtask

    task automatic end_run();
        bus.Run = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0] v;
        bus.Run = 1'b0;
        bus.ClearA_LoadB = 1'b0;
        bus.Din = 8'h00;
        repeat (2) @(posedge Clk);
        #1;
        check_all_zero("reset");
        @(negedge Clk);
        Reset_n = 1'b1;
        tick();

        load(8'h07);
        do_run(8'hFD, 1'b0, 0);
        check("neg3x7", {16'h0, bus.Aval, bus.Bval}, 32'h0000FFEB);
        end_run();

        load(8'h80);
        do_run(8'h80, 1'b0, 0);
        check("min_x_min", {16'h0, bus.Aval, bus.Bval}, 32'h00004000);
        end_run();

        load(8'hFF);
        do_run(8'h7F, 1'b0, 40);
        check("m1x127", {16'h0, bus.Aval, bus.Bval}, 32'h0000FF81);
        end_run();

        load(8'h00);
        do_run(8'($urandom), 1'b1, 0);
        check("zero_mult", {16'h0, bus.Aval, bus.Bval}, 32'h0);
        end_run();

        // Run and load together in IDLE: load only
        bus.Run = 1'b1;
        bus.ClearA_LoadB = 1'b1;
        bus.Din = 8'h5A;
        tick();
        bus.Run = 1'b0;
        bus.ClearA_LoadB = 1'b0;
        model_b = 8'h5A;
        check("both_busy", 32'(bus.Busy), 32'h0);
        check("both_b", 32'(bus.Bval), 32'h5A);
        tick();
        check("both_idle", 32'(bus.Busy), 32'h0);

        // Load while in DONE stays in DONE
        do_run(8'h13, 1'b0, 0);
        bus.ClearA_LoadB = 1'b1;
        bus.Din = 8'hC3;
        tick();
        bus.ClearA_LoadB = 1'b0;
        model_b = 8'hC3;
        check("done_load_b", 32'(bus.Bval), 32'hC3);
        check("done_load_a", 32'(bus.Aval), 32'h0);
        check("done_load_x", 32'(bus.Xval), 32'h0);
        tick();
        check("done_stay", 32'(bus.Busy), 32'h0);
        end_run();

        // Reset in the middle of a run
        bus.Run = 1'b1;
        bus.Din = 8'($urandom);
        tick();
        repeat (8) tick();
        Reset_n = 1'b0;
        #1;
        check_all_zero("midreset");
        bus.Run = 1'b0;
        tick();
        tick();
        Reset_n = 1'b1;
        model_b = 8'h00;
        tick();
        load(8'hE9);
        do_run(8'h25, 1'b0, 0);
        end_run();

        for (int i = 0; i < 24; i++) begin
            if ($urandom_range(0, 2) != 0) begin
                v = 8'($urandom);
                load(v);
            end
            v = 8'($urandom);
            do_run(v, 1'($urandom), int'($urandom_range(0, 3)));
            end_run();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
